linebuf_nrow_window: RTL

Parametrised N-row line buffer for the infrared image-processing pipeline. It accepts a raster pixel stream and stores the previous `P_ROWS` rows in rotating single-port RAMs. For every input pixel it emits a vertically aligned column of `P_ROWS+1` pixels. It sits between the sensor/DMA stream and the 3×3, 5×5 (or larger) spatial filter windows, replacing fixed two-row buffers with a depth-configurable, frame-aware one.

---
 rtl/linebuf_nrow_window_pkg.sv | 33 +++
 rtl/linebuf_nrow_window_if.sv | 32 +++
 rtl/linebuf_nrow_window_line_ram.sv | 50 +++++
 rtl/linebuf_nrow_window.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/linebuf_nrow_window_pkg.sv
// -----------------------------------------------------------------------------
// linebuf_pkg
// Shared definitions for the N-row line buffer:
//   - clog2 helper for parameter-derived widths
//   - ROW_IDX_W: width of the frame row index reported on o_row
//   - slice(): extracts pixel slice k from a packed window column
// -----------------------------------------------------------------------------
package linebuf_pkg;

    localparam int ROW_IDX_W    = 16;
    // Upper bounds for the generic slice() helper.
    localparam int LB_MAX_COL_W = 1024;
    localparam int LB_MAX_DW    = 64;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    // Returns the k-th dw-bit slice of a packed column (k = 0 is the LSB slice).
    function automatic logic [LB_MAX_DW-1:0] slice(input logic [LB_MAX_COL_W-1:0] col_vec,
                                                   input int k,
                                                   input int dw = 8);
        logic [LB_MAX_COL_W-1:0] shifted;
        logic [LB_MAX_DW-1:0]    mask;
        shifted = col_vec >> (k * dw);
        mask    = {LB_MAX_DW{1'b1}} >> (LB_MAX_DW - dw);
        return shifted[LB_MAX_DW-1:0] & mask;
    endfunction

endpackage

// File: rtl/linebuf_nrow_window_if.sv
// -----------------------------------------------------------------------------
// linebuf_nrow_window_if
// Pixel stream in / window column out bundle for linebuf_nrow_window.
//   i_sof, i_valid, i_data : raster pixel stream (source -> buffer)
//   o_valid, o_col, o_eol, o_row : vertically aligned column (buffer -> filter)
// Modports: slave = line buffer side, master = stream source / consumer side.
// -----------------------------------------------------------------------------
interface linebuf_nrow_window_if #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ROWS       = 2
);
    import linebuf_pkg::*;

    logic                                 i_sof;
    logic                                 i_valid;
    logic [P_DATA_WIDTH-1:0]              i_data;
    logic                                 o_valid;
    logic [(P_ROWS+1)*P_DATA_WIDTH-1:0]   o_col;
    logic                                 o_eol;
    logic [ROW_IDX_W-1:0]                 o_row;

    modport slave (
        input  i_sof, i_valid, i_data,
        output o_valid, o_col, o_eol, o_row
    );

    modport master (
        output i_sof, i_valid, i_data,
        input  o_valid, o_col, o_eol, o_row
    );

endinterface

// File: rtl/linebuf_nrow_window_line_ram.sv
// -----------------------------------------------------------------------------
// line_ram
// Single-port, read-first RAM holding one image row, 1-cycle read latency.
//   clka    : clock
//   i_en    : port enable (read, and write when i_we)
//   i_we    : write enable
//   i_addr  : column address
//   i_wdata : write data
//   o_rdata : registered read data (old contents on a write cycle)
// -----------------------------------------------------------------------------
module line_ram
    import linebuf_pkg::*;
#(
    parameter int P_DEPTH      = 256,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 12
) (
    input  logic                    clka,
    input  logic                    i_en,
    input  logic                    i_we,
    input  logic [P_ADDR_WIDTH-1:0] i_addr,
    input  logic [P_DATA_WIDTH-1:0] i_wdata,
    output logic [P_DATA_WIDTH-1:0] o_rdata
);

    localparam int IW = (P_DEPTH > 1) ? clog2(P_DEPTH) : 1;

    logic [P_DATA_WIDTH-1:0] r_mem [P_DEPTH];
    logic [P_DATA_WIDTH-1:0] r_rdata;
    logic                    w_in_range;
    logic [IW-1:0]           w_idx;

    // Out-of-range addresses are ignored rather than aliased onto real rows.
    assign w_in_range = ({1'b0, i_addr} < (P_ADDR_WIDTH+1)'(P_DEPTH));
    assign w_idx      = i_addr[IW-1:0];

    // NOTE: non-blocking assignments make the read return the pre-write
    // contents (read-first); the array has no reset so it maps onto block RAM.
    always_ff @(posedge clka) begin
        if (i_en && w_in_range) begin
            r_rdata <= r_mem[w_idx];
            if (i_we) begin
                r_mem[w_idx] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/linebuf_nrow_window.sv
// -----------------------------------------------------------------------------
// linebuf_nrow_window
// Depth-configurable, frame-aware line buffer. Stores the previous P_ROWS rows
// in rotating single-port RAMs and emits a column of P_ROWS+1 pixels per input
// pixel, one cycle later (oldest row in the MSB slice, current pixel in LSB).
//   clka  : clock
//   rsta  : synchronous active-high reset
//   io_lb : linebuf_nrow_window_if.slave (i_sof/i_valid/i_data in,
//           o_valid/o_col/o_eol/o_row out)
// Optional feature: define LINEBUF_BORDER_REPLICATE_EN to emit columns from
// row 0 with missing rows replaced by the row-0 pixel of the frame.
// -----------------------------------------------------------------------------
module linebuf_nrow_window
    import linebuf_pkg::*;
#(
    parameter int P_ROW_WIDTH  = 256,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 12,
    parameter int P_ROWS       = 2
) (
    input  logic                    clka,
    input  logic                    rsta,
    linebuf_nrow_window_if.slave    io_lb
);

    localparam int PW = (P_ROWS > 1) ? clog2(P_ROWS) : 1;
    localparam int FW = clog2(P_ROWS + 1);
    localparam int CW = (P_ROWS + 1) * P_DATA_WIDTH;

    // Counters
    logic [P_ADDR_WIDTH-1:0] r_col,         w_col;
    logic [PW-1:0]           r_wr_ptr,      w_wr_ptr;
    logic [FW-1:0]           r_rows_filled, w_rows_filled;
    logic [ROW_IDX_W-1:0]    r_row_idx,     w_row_idx;
    logic                    w_accept;
    logic                    w_frame_start;
    logic                    w_last_col;
    logic                    w_out_ok;

    // Output-side registers
    logic                    r_valid;
    logic                    r_eol;
    logic [P_DATA_WIDTH-1:0] r_cur;
    logic [PW-1:0]           r_sel;
    logic [ROW_IDX_W-1:0]    r_out_row;
`ifdef LINEBUF_BORDER_REPLICATE_EN
    logic [FW-1:0]           r_out_filled;
`endif

    logic [P_DATA_WIDTH-1:0] w_ram_q [P_ROWS];
    logic [CW-1:0]           w_col_vec;
    logic [CW-1:0]           w_out_vec;

    assign w_accept      = io_lb.i_valid;
    assign w_frame_start = io_lb.i_sof & io_lb.i_valid;

    // A frame start restarts every counter before this pixel is processed.
    assign w_col         = w_frame_start ? '0 : r_col;
    assign w_wr_ptr      = w_frame_start ? '0 : r_wr_ptr;
    assign w_rows_filled = w_frame_start ? '0 : r_rows_filled;
    assign w_row_idx     = w_frame_start ? '0 : r_row_idx;
    assign w_last_col    = (w_col == P_ADDR_WIDTH'(P_ROW_WIDTH - 1));

`ifdef LINEBUF_BORDER_REPLICATE_EN
    assign w_out_ok = 1'b1;
`else
    assign w_out_ok = (w_rows_filled == FW'(P_ROWS));
`endif

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_col         <= '0;
            r_wr_ptr      <= '0;
            r_rows_filled <= '0;
            r_row_idx     <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col         <= '0;
                r_wr_ptr      <= (w_wr_ptr == PW'(P_ROWS - 1)) ? '0 : w_wr_ptr + 1'b1;
                r_rows_filled <= (w_rows_filled == FW'(P_ROWS)) ? w_rows_filled
                                                               : w_rows_filled + 1'b1;
                r_row_idx     <= (&w_row_idx) ? w_row_idx : w_row_idx + 1'b1;
            end else begin
                r_col         <= w_col + 1'b1;
                r_wr_ptr      <= w_wr_ptr;
                r_rows_filled <= w_rows_filled;
                r_row_idx     <= w_row_idx;
            end
        end
    end

    // All RAMs read the current column; only RAM[wr_ptr] (oldest row) is written.
    for (genvar g = 0; g < P_ROWS; g++) begin : g_ram
        line_ram #(
            .P_DEPTH      (P_ROW_WIDTH),
            .P_DATA_WIDTH (P_DATA_WIDTH),
            .P_ADDR_WIDTH (P_ADDR_WIDTH)
        ) u_ram (
            .clka    (clka),
            .i_en    (w_accept),
            .i_we    (w_wr_ptr == PW'(g)),
            .i_addr  (w_col),
            .i_wdata (io_lb.i_data),
            .o_rdata (w_ram_q[g])
        );
    end

    // Side-band state registered alongside the RAM read so it lines up with it.
    always_ff @(posedge clka) begin
        if (rsta) begin
            r_valid      <= 1'b0;
            r_eol        <= 1'b0;
            r_cur        <= '0;
            r_sel        <= '0;
            r_out_row    <= '0;
`ifdef LINEBUF_BORDER_REPLICATE_EN
            r_out_filled <= '0;
`endif
        end else begin
            r_valid <= w_accept & w_out_ok;
            if (w_accept) begin
                r_eol        <= w_last_col;
                r_cur        <= io_lb.i_data;
                r_sel        <= w_wr_ptr;
                r_out_row    <= w_row_idx;
`ifdef LINEBUF_BORDER_REPLICATE_EN
                r_out_filled <= w_rows_filled;
`endif
            end
        end
    end

    // Rotation mux: slice k comes from RAM[(wr_ptr - k) mod P_ROWS].
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        int src;
        src       = 0;
        w_col_vec = '0;
        w_col_vec[P_DATA_WIDTH-1:0] = r_cur;
        for (int k = 1; k <= P_ROWS; k++) begin
            src = int'(r_sel) - k;
            if (src < 0) begin
                src = src + P_ROWS;
            end
            for (int j = 0; j < P_ROWS; j++) begin
                if (j == src) begin
                    w_col_vec[k*P_DATA_WIDTH +: P_DATA_WIDTH] = w_ram_q[j];
                end
            end
        end
    end

`ifdef LINEBUF_BORDER_REPLICATE_EN
    // Rows not yet stored (k > rows_filled) repeat slice rows_filled, which is
    // the row-0 pixel of this frame (the current pixel while on row 0).
    always_comb begin
        w_out_vec = w_col_vec;
        for (int k = 1; k <= P_ROWS; k++) begin
            if (k > int'(r_out_filled)) begin
                w_out_vec[k*P_DATA_WIDTH +: P_DATA_WIDTH] =
                    P_DATA_WIDTH'(slice(LB_MAX_COL_W'(w_col_vec), int'(r_out_filled), P_DATA_WIDTH));
            end
        end
    end
`else
    assign w_out_vec = w_col_vec;
`endif

    // Outputs are zeroed while invalid so stale RAM contents never leak out.
    assign io_lb.o_valid = r_valid;
    assign io_lb.o_eol   = r_valid & r_eol;
    assign io_lb.o_col   = r_valid ? w_out_vec : '0;
    assign io_lb.o_row   = r_out_row;

endmodule
